// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder controller: FSM state encoding,
// default operand width and the bit-counter width helper.
package serial_adder_pkg;

    localparam int DEF_WIDTH = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // One extra bit so the counter can reach WIDTH without wrapping.
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// The team's 1-bit full_adder cell, sequenced by serial_adder_ctrl.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic carry_out
);

    assign sum       = a ^ b ^ c_in;
    assign carry_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: adds two WIDTH-bit operands LSB first through
// one full_adder over WIDTH cycles. Define SERIAL_ADDER_SUB_EN to add the sub port.
module serial_adder_ctrl
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy,
    output logic             done
);

    localparam int CW = cnt_width(WIDTH);

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_a_sh;
    logic [WIDTH-1:0] r_b_sh;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_sum;
    logic             r_cout;

    logic             w_fa_sum;
    logic             w_fa_co;
    logic             w_last;
    logic [WIDTH-1:0] w_sum_next;
    logic [WIDTH-1:0] w_b_load;
    logic             w_c_load;

    full_adder u_fa (
        .a         (r_a_sh[0]),
        .b         (r_b_sh[0]),
        .c_in      (r_carry),
        .sum       (w_fa_sum),
        .carry_out (w_fa_co)
    );

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1; the requester's cin is ignored in that mode.
    assign w_b_load = sub ? ~op_b : op_b;
    assign w_c_load = sub ? 1'b1  : cin;
`else
    assign w_b_load = op_b;
    assign w_c_load = cin;
`endif

    assign w_last = (r_state == ST_RUN) && (r_cnt == CW'(WIDTH - 1));

    always_comb begin
        w_sum_next            = r_sum >> 1;
        w_sum_next[WIDTH-1]   = w_fa_sum;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_next_state = ST_RUN;
                end
            end
            ST_RUN: begin
                busy = 1'b1;
                if (w_last) begin
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_sh  <= '0;
            r_b_sh  <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_a_sh  <= op_a;
                        r_b_sh  <= w_b_load;
                        r_carry <= w_c_load;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_cout  <= 1'b0;
                    end
                end
                ST_RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_fa_co;
                    r_a_sh  <= r_a_sh >> 1;
                    r_b_sh  <= r_b_sh >> 1;
                    r_cnt   <= r_cnt + CW'(1);
                    if (w_last) begin
                        r_cout <= w_fa_co;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
